pulse_peak_detect: RTL and testbench

- Downstream consumer of the PZC zeroing stage. Takes the pole-zero-corrected signed pulse stream, one sample per clk.
- Detects threshold crossings, tracks each pulse maximum, confirms the peak on the falling edge, and emits a scaled, saturated amplitude with a timestamp over a valid/ready handshake.
- Applies a dead-time after each event and counts dropped and rejected events for the HPS histogram/readout logic.

---
 rtl/pulse_peak_detect.sv | 162 ++++++++++++++++
 tb/tb_pulse_peak_detect.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_peak_detect.sv
// Pulse peak detector: threshold trigger, running-max tracking, fall-confirmed peak, and a scaled,
// saturated amplitude plus timestamp over valid/ready. Optional macro: PILEUP_REJECT_EN.
module pulse_peak_detect #(
  parameter int NBITS_IN     = 28,
  parameter int NBITS_OUT    = 16,
  parameter int THRESHOLD    = 200,
  parameter int FALL_CONFIRM = 3,
  parameter int MAX_RISE     = 1024,
  parameter int HOLDOFF      = 64,
  parameter int SHIFT        = 4,
  parameter int NBITS_TS     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [NBITS_IN-1:0] in,
  output logic [NBITS_OUT-1:0]       pk_amp,
  output logic [NBITS_TS-1:0]        pk_ts,
  output logic                       pk_valid,
  input  logic                       pk_ready,
  output logic                       busy,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                err_cnt
);

  localparam int RW = $clog2(MAX_RISE + 1);
  localparam int FW = $clog2(FALL_CONFIRM + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic signed [NBITS_IN-1:0] THR     = NBITS_IN'(THRESHOLD);
  localparam logic signed [NBITS_IN-1:0] AMP_MAX = NBITS_IN'((64'd1 << NBITS_OUT) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_HOLD} state_t;

  state_t                     r_state;
  logic signed [NBITS_IN-1:0] r_peak;
  logic [NBITS_TS-1:0]        r_ts;
  logic [NBITS_TS-1:0]        r_ts_lat;
  logic [RW-1:0]              r_rise_cnt;
  logic [FW-1:0]              r_fall_cnt;
  logic [HW-1:0]              r_hold_cnt;
  logic                       r_valid;
  logic [NBITS_OUT-1:0]       r_amp;
  logic [NBITS_TS-1:0]        r_pk_ts;
  logic [15:0]                r_drop_cnt;
  logic [15:0]                r_err_cnt;

  logic                       w_above;
  logic                       w_new_max;
  logic signed [NBITS_IN-1:0] w_peak_nxt;
  logic signed [NBITS_IN-1:0] w_shifted;
  logic [FW-1:0]              w_fall_nxt;
  logic [RW-1:0]              w_rise_nxt;
  logic                       w_confirm;
  logic                       w_pileup;
  logic                       w_emit;
  logic                       w_err;
  logic                       w_xfer;
  logic [NBITS_OUT-1:0]       w_amp;

  always_comb begin
    // NOTE: operands are declared signed so every compare and >>> is two's-complement;
    // one unsigned operand would silently turn the whole expression unsigned.
    w_above    = (in > THR);
    w_new_max  = (in >= r_peak);
    w_peak_nxt = w_new_max ? in : r_peak;
    w_fall_nxt = w_new_max ? '0 : r_fall_cnt + 1'b1;
    w_rise_nxt = r_rise_cnt + 1'b1;
    w_confirm  = (w_fall_nxt == FW'(FALL_CONFIRM)) || !w_above;
    w_shifted  = w_peak_nxt >>> SHIFT;
    // NOTE: every branch assigns w_amp, so no latch is inferred.
    if (w_shifted[NBITS_IN-1])      w_amp = '0;
    else if (w_shifted > AMP_MAX)   w_amp = '1;
    else                            w_amp = w_shifted[NBITS_OUT-1:0];
  end

`ifdef PILEUP_REJECT_EN
  logic signed [NBITS_IN-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= in;
  end

  // A sharp re-rise after the peak has started falling means a second pulse landed on the first.
  assign w_pileup = (r_fall_cnt != '0) && (in > r_prev + THR);
`else
  assign w_pileup = 1'b0;
`endif

  assign w_emit = (r_state == S_RISE) && !w_pileup && w_confirm;
  assign w_err  = (r_state == S_RISE) && (w_pileup || (!w_confirm && (w_rise_nxt == RW'(MAX_RISE))));
  assign w_xfer = r_valid && pk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_peak     <= '0;
      r_ts       <= '0;
      r_ts_lat   <= '0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_hold_cnt <= '0;
      r_valid    <= 1'b0;
      r_amp      <= '0;
      r_pk_ts    <= '0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_ts <= r_ts + 1'b1;

      // Output holding register: a new event only replaces the held one if it is leaving this cycle.
      if (w_emit) begin
        if (!r_valid || w_xfer) begin
          r_valid <= 1'b1;
          r_amp   <= w_amp;
          r_pk_ts <= r_ts_lat;
        end else if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (w_above) begin
            r_state    <= S_RISE;
            r_peak     <= in;
            r_ts_lat   <= r_ts;
            r_fall_cnt <= '0;
            r_rise_cnt <= RW'(1);
          end
        end
        S_RISE: begin
          if (w_emit || w_err) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end else begin
            r_peak     <= w_peak_nxt;
            r_fall_cnt <= w_fall_nxt;
            r_rise_cnt <= w_rise_nxt;
          end
        end
        S_HOLD: begin
          if ((r_hold_cnt >= HW'(HOLDOFF)) && !w_above) r_state <= S_IDLE;
          else if (r_hold_cnt != HW'(HOLDOFF))          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pk_amp   = r_amp;
  assign pk_ts    = r_pk_ts;
  assign pk_valid = r_valid;
  assign busy     = (r_state != S_IDLE);
  assign drop_cnt = r_drop_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_pulse_peak_detect.sv
// Bench for pulse_peak_detect: directed + random sample stream, event-level reference model,
// scoreboard queue drained by an independent monitor on each valid/ready transfer.
module tb_pulse_peak_detect;

  localparam int THRESHOLD    = 200;
  localparam int FALL_CONFIRM = 3;
  localparam int MAX_RISE     = 1024;
  localparam int HOLDOFF      = 64;
  localparam int SHIFT        = 4;
`ifdef PILEUP_REJECT_EN
  localparam int PILEUP = 1;
`else
  localparam int PILEUP = 0;
`endif

  typedef struct {
    int     amp;
    longint ts;
  } event_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [27:0] in;
  logic [15:0]        pk_amp;
  logic [31:0]        pk_ts;
  logic               pk_valid;
  logic               pk_ready;
  logic               busy;
  logic [15:0]        drop_cnt;
  logic [15:0]        err_cnt;

  pulse_peak_detect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .pk_amp   (pk_amp),
    .pk_ts    (pk_ts),
    .pk_valid (pk_valid),
    .pk_ready (pk_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus stream: one sample and one ready bit per cycle.
  int s_in[$];
  bit s_rdy[$];

  task automatic put(input int v, input bit r);
    s_in.push_back(v);
    s_rdy.push_back(r);
  endtask

  task automatic zeros(input int n, input bit r);
    for (int i = 0; i < n; i++) put(0, r);
  endtask

  // Reference model: event detector described in terms of pulses, not hardware states.
  event_t sb[$];
  event_t obs[$];
  bit     m_tracking = 0;
  bit     m_dead     = 0;
  int     m_peak, m_fall, m_rise, m_hold, m_prev;
  longint m_ts;
  bit     m_valid    = 0;
  int     m_drop     = 0;
  int     m_err      = 0;

  function automatic int scale(input int p);
    int v;
    v = p >>> SHIFT;
    if (v < 0)     return 0;
    if (v > 65535) return 65535;
    return v;
  endfunction

  task automatic model_step(input int idx, input int x, input bit r);
    bit     emit;
    bit     xfer;
    event_t e;
    emit = 0;
    xfer = m_valid && r;
    if (m_tracking) begin
      m_rise++;
      if (PILEUP != 0 && m_fall >= 1 && x > m_prev + THRESHOLD) begin
        if (m_err < 65535) m_err++;
        m_tracking = 0; m_dead = 1; m_hold = 0;
      end else begin
        if (x >= m_peak) begin m_peak = x; m_fall = 0; end
        else m_fall++;
        if (m_fall == FALL_CONFIRM || x <= THRESHOLD) begin
          emit = 1;
          m_tracking = 0; m_dead = 1; m_hold = 0;
        end else if (m_rise == MAX_RISE) begin
          if (m_err < 65535) m_err++;
          m_tracking = 0; m_dead = 1; m_hold = 0;
        end
      end
    end else if (m_dead) begin
      if (m_hold >= HOLDOFF && x <= THRESHOLD) m_dead = 0;
      else m_hold++;
    end else if (x > THRESHOLD) begin
      m_tracking = 1; m_peak = x; m_ts = idx; m_fall = 0; m_rise = 1;
    end
    m_prev = x;
    if (emit) begin
      if (!m_valid || xfer) begin
        e.amp = scale(m_peak);
        e.ts  = m_ts;
        sb.push_back(e);
        m_valid = 1;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  // Monitor: every observed transfer pops the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pk_valid === 1'b1 && pk_ready === 1'b1) begin
      event_t e;
      event_t o;
      o.amp = int'(pk_amp);
      o.ts  = longint'(pk_ts);
      obs.push_back(o);
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pk_amp", o.amp, e.amp);
        check("pk_ts", o.ts, e.ts);
      end
    end
  end

  int t_single, t_sat, t_bp_a, t_dead1, t_dead3, t_dir_end;

  initial begin
    rst_n    = 1'b0;
    in       = '0;
    pk_ready = 1'b0;

    // Directed part.
    zeros(5, 1);
    t_single = s_in.size();
    foreach (s_in[i]) ;
    put(300, 1); put(800, 1); put(1600, 1); put(1500, 1); put(1400, 1); put(1300, 1); put(0, 1);
    zeros(80, 1);
    t_sat = s_in.size();
    put(1 << 22, 1); put(0, 1);
    zeros(80, 1);
    for (int i = 0; i < 20; i++) put(-5000, 1);
    zeros(10, 1);
    t_bp_a = s_in.size();
    put(500, 0); put(1000, 0); put(0, 0);
    zeros(80, 0);
    put(700, 0); put(2000, 0); put(0, 0);
    zeros(10, 0);
    zeros(80, 1);
    for (int i = 0; i < 1100; i++) put(5000, 1);
    zeros(80, 1);
    t_dead1 = s_in.size();
    put(400, 1); put(1200, 1); put(0, 1);
    zeros(10, 1);
    put(400, 1); put(1200, 1); put(0, 1);
    zeros(67, 1);
    t_dead3 = s_in.size();
    put(400, 1); put(1200, 1); put(0, 1);
    zeros(80, 1);
    put(1000, 1); put(900, 1); put(1500, 1); put(0, 1);
    zeros(80, 1);
    t_dir_end = s_in.size();

    // Random part.
    for (int k = 0; k < 150; k++) begin
      int kind;
      int top;
      int p;
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       top = 2000;
        1:       top = 1 << 20;
        default: top = 1 << 26;
      endcase
      case (kind)
        0: for (int i = 0; i < int'($urandom_range(1, 6)); i++)
             put(int'($urandom_range(0, 600)) - 400, $urandom_range(0, 9) < 7);
        1: for (int i = 0; i < int'($urandom_range(60, 100)); i++)
             put(int'($urandom_range(0, 600)) - 400, $urandom_range(0, 9) < 7);
        2: for (int i = 0; i < int'($urandom_range(1, 10)); i++)
             put(int'($urandom_range(THRESHOLD + 1, top)), $urandom_range(0, 9) < 7);
        default: begin
          p = int'($urandom_range(1000, top));
          put(p / 4, $urandom_range(0, 9) < 7);
          put(p / 2, $urandom_range(0, 9) < 7);
          put(p, $urandom_range(0, 9) < 7);
          for (int i = 1; i <= int'($urandom_range(1, 5)); i++)
            put(p - i * 100, $urandom_range(0, 9) < 7);
        end
      endcase
    end

    // Tail: drain, then hold one event and leave a pulse mid-rise for the reset test.
    zeros(100, 1);
    put(500, 0); put(900, 0); put(0, 0);
    zeros(70, 0);
    put(600, 0); put(700, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_pk_valid", pk_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_pk_amp", pk_amp, 0);
    check("reset_pk_ts", pk_ts, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_err_cnt", err_cnt, 0);

    for (int j = 0; j < s_in.size(); j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b1;
      check("busy", busy, m_tracking || m_dead);
      check("pk_valid", pk_valid, m_valid);
      if (j == t_dir_end) begin
        check("dir_drop_cnt", drop_cnt, 1);
        check("dir_err_cnt", err_cnt, 1 + PILEUP);
        check("dir_event_count", obs.size(), 6 - PILEUP);
        check("single_amp", obs[0].amp, 100);
        check("single_ts", obs[0].ts, t_single);
        check("sat_amp", obs[1].amp, 65535);
        check("sat_ts", obs[1].ts, t_sat);
        check("bp_held_amp", obs[2].amp, 62);
        check("bp_held_ts", obs[2].ts, t_bp_a);
        check("dead_first_ts", obs[3].ts, t_dead1);
        check("dead_rearm_amp", obs[4].amp, 75);
        check("dead_rearm_ts", obs[4].ts, t_dead3);
        if (obs.size() > 5) check("merged_pulse_amp", obs[5].amp, 93);
      end
      in       = 28'(s_in[j]);
      pk_ready = s_rdy[j];
      model_step(j, s_in[j], s_rdy[j]);
    end
    @(posedge clk);
    #1;
    check("end_busy", busy, m_tracking || m_dead);
    check("end_pk_valid", pk_valid, m_valid);
    check("end_drop_cnt", drop_cnt, m_drop);
    check("end_err_cnt", err_cnt, m_err);

    // Asynchronous reset mid-rise, with an event held on the output.
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_pk_valid", pk_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_pk_amp", pk_amp, 0);
    check("midreset_pk_ts", pk_ts, 0);
    check("midreset_drop_cnt", drop_cnt, 0);
    check("midreset_err_cnt", err_cnt, 0);
    check("held_events_left", sb.size(), 1);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
